// File: rtl/rlwe_out_axi_wr_master_pkg.sv
// Shared types and AXI constants for the RLWE output-FIFO AXI4 write master.
// Enumerates the FSM states and the 4 KB page-beat limit.
package rlwe_out_axi_wr_master_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_64B   = 3'd6;

  // 64-byte beats in one 4 KB page
  localparam logic [6:0] PAGE_BEATS = 7'd64;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIFO,
    AW,
    W,
    B,
    FINISH
  } rlwe_wr_state_e;

endpackage

// File: rtl/rlwe_out_axi_wr_master_skid_buf.sv
// Two-entry buffer between the 1-cycle-latency FIFO read port and the W channel.
// credit tells the reader a new read still fits once it lands next cycle.
module rlwe_wr_skid_buf #(
  parameter int DW = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic [DW-1:0] in_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          credit
);

  logic          inflight;
  logic [1:0]    count;
  logic [DW-1:0] e0;
  logic [DW-1:0] e1;
  logic          push;
  logic          pop;

  assign push      = inflight;
  assign out_valid = (count != 2'd0);
  assign out_data  = e0;
  assign pop       = out_valid && out_ready;

  // occupancy + in-flight after this cycle's pop must leave room for one more
  assign credit = ({1'b0, count} + {2'b00, inflight})
                  <= (3'd1 + {2'b00, pop});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      e0       <= '0;
      e1       <= '0;
    end else begin
      inflight <= issue;
      count    <= count + {1'b0, push} - {1'b0, pop};
      if (push && pop) begin
        if (count == 2'd1) begin
          e0 <= in_data;
        end else begin
          e0 <= e1;
          e1 <= in_data;
        end
      end else if (push) begin
        if (count == 2'd0) e0 <= in_data;
        else               e1 <= in_data;
      end else if (pop) begin
        e0 <= e1;
      end
    end
  end

endmodule

// File: rtl/rlwe_out_axi_wr_master.sv
// AXI4 write master draining one RLWE output line buffer into DDR.
// Optional perf counters are built when RLWE_OUT_WR_PERF_EN is defined.
module rlwe_out_axi_wr_master
  import rlwe_out_axi_wr_master_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = 512,
  parameter int AXI_ADDR_WIDTH  = 64,
  parameter int AXI_ID_WIDTH    = 16,
  parameter int LINE_ADDR_WIDTH = 9,
  parameter int MAX_BURST       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef RLWE_OUT_WR_PERF_EN
  output logic [31:0]                 perf_busy_cycles,
  output logic [31:0]                 perf_wstall_cycles,
`endif
  input  logic                        start,
  input  logic [AXI_ADDR_WIDTH-1:0]   base_addr,
  input  logic [LINE_ADDR_WIDTH:0]    num_lines,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  input  logic                        fifo_empty,
  output logic [LINE_ADDR_WIDTH-1:0]  fifo_rd_addr,
  output logic                        fifo_rd_en,
  input  logic [AXI_DATA_WIDTH-1:0]   fifo_rd_data,
  output logic                        fifo_rd_finish,
  output logic [AXI_ID_WIDTH-1:0]     awid,
  output logic [AXI_ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [AXI_DATA_WIDTH-1:0]   wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [AXI_ID_WIDTH-1:0]     bid,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready
);

  localparam int LW = LINE_ADDR_WIDTH + 1;

  rlwe_wr_state_e state;
  rlwe_wr_state_e state_nx;

  logic [AXI_ADDR_WIDTH-1:0]  cur_addr;
  logic [LW-1:0]              remaining;
  logic [LW-1:0]              len;
  logic [LW-1:0]              page_left;
  logic [LW-1:0]              fetch_cnt;
  logic [LW-1:0]              beat_cnt;
  logic [LINE_ADDR_WIDTH-1:0] rd_addr;
  logic                       zero_cmd;
  logic                       start_ok;
  logic                       rd_en;
  logic                       w_hs;
  logic                       b_hs;
  logic                       last_beat;
  logic                       sk_valid;
  logic                       sk_ready;
  logic                       sk_credit;
  logic [AXI_DATA_WIDTH-1:0]  sk_data;
  logic                       unused_bid;

  assign unused_bid = ^bid;

  assign page_left = LW'(PAGE_BEATS - {1'b0, cur_addr[11:6]});

  // burst length: capped by MAX_BURST, lines left, and the 4 KB page
  always_comb begin
    len = LW'(MAX_BURST);
    if (remaining < len) len = remaining;
    if (page_left < len) len = page_left;
  end

  assign start_ok  = start && (state == IDLE);
  assign last_beat = (beat_cnt == len - LW'(1));
  assign sk_ready  = (state == W) && wready;
  assign wvalid    = (state == W) && sk_valid;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bvalid && bready;
  assign rd_en     = ((state == AW) || (state == W))
                     && (fetch_cnt < len) && sk_credit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    busy           = 1'b0;
    done           = 1'b0;
    fifo_rd_finish = 1'b0;
    awvalid        = 1'b0;
    bready         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (num_lines == '0) ? FINISH : WAIT_FIFO;
        end
      end
      WAIT_FIFO: begin
        busy = 1'b1;
        if (!fifo_empty) state_nx = AW;
      end
      AW: begin
        busy    = 1'b1;
        awvalid = 1'b1;
        if (awready) state_nx = W;
      end
      W: begin
        busy = 1'b1;
        if (w_hs && last_beat) state_nx = B;
      end
      B: begin
        busy   = 1'b1;
        bready = 1'b1;
        if (bvalid) begin
          state_nx = (remaining == len) ? FINISH : AW;
        end
      end
      FINISH: begin
        done           = 1'b1;
        fifo_rd_finish = !zero_cmd;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      fetch_cnt <= '0;
      beat_cnt  <= '0;
      rd_addr   <= '0;
      err       <= 1'b0;
      zero_cmd  <= 1'b0;
    end else begin
      if (start_ok) begin
        cur_addr  <= base_addr;
        remaining <= num_lines;
        fetch_cnt <= '0;
        beat_cnt  <= '0;
        rd_addr   <= '0;
        err       <= 1'b0;
        zero_cmd  <= (num_lines == '0);
      end
      if (rd_en) begin
        rd_addr   <= rd_addr + LINE_ADDR_WIDTH'(1);
        fetch_cnt <= fetch_cnt + LW'(1);
      end
      if (w_hs) beat_cnt <= beat_cnt + LW'(1);
      if (b_hs) begin
        if (bresp != AXI_RESP_OKAY) err <= 1'b1;
        cur_addr  <= cur_addr + (AXI_ADDR_WIDTH'(len) << 6);
        remaining <= remaining - len;
        fetch_cnt <= '0;
        beat_cnt  <= '0;
      end
    end
  end

  rlwe_wr_skid_buf #(
    .DW (AXI_DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .issue     (rd_en),
    .in_data   (fifo_rd_data),
    .out_ready (sk_ready),
    .out_valid (sk_valid),
    .out_data  (sk_data),
    .credit    (sk_credit)
  );

  assign fifo_rd_en   = rd_en;
  assign fifo_rd_addr = rd_addr;

  // channel fields read as zero whenever their valid is low
  assign awid    = '0;
  assign awaddr  = awvalid ? cur_addr : '0;
  assign awlen   = awvalid ? 8'(len - LW'(1)) : 8'd0;
  assign awsize  = awvalid ? AXI_SIZE_64B : 3'd0;
  assign awburst = awvalid ? AXI_BURST_INCR : 2'd0;
  assign wdata   = wvalid ? sk_data : '0;
  assign wstrb   = wvalid ? '1 : '0;
  assign wlast   = wvalid && last_beat;

`ifdef RLWE_OUT_WR_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cycles   <= '0;
      perf_wstall_cycles <= '0;
    end else if (start_ok) begin
      perf_busy_cycles   <= '0;
      perf_wstall_cycles <= '0;
    end else begin
      if (busy && !(&perf_busy_cycles)) begin
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
      if (wvalid && !wready && !(&perf_wstall_cycles)) begin
        perf_wstall_cycles <= perf_wstall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rlwe_out_axi_wr_master.sv
// Scoreboard bench for rlwe_out_axi_wr_master: expected AW/W beats are
// queued by the stimulus and popped by a monitor on each handshake.
module tb_rlwe_out_axi_wr_master;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [63:0]  base_addr;
  logic [9:0]   num_lines;
  logic         busy, done, err;
  logic         fifo_empty;
  logic [8:0]   fifo_rd_addr;
  logic         fifo_rd_en;
  logic [511:0] fifo_rd_data = '0;
  logic         fifo_rd_finish;
  logic [15:0]  awid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid, awready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast, wvalid, wready;
  logic [15:0]  bid;
  logic [1:0]   bresp;
  logic         bvalid, bready;
`ifdef RLWE_OUT_WR_PERF_EN
  logic [31:0]  perf_busy_cycles, perf_wstall_cycles;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int fin_cnt = 0;
  int done_cnt = 0;
  int bcount = 0;
  int slverr_at = -1;
  bit wr_rand = 1'b0;
  logic [15:0] tag = '0;

  logic [92:0]  aw_q[$];
  logic [576:0] w_q[$];

  always #5 clk = ~clk;

  rlwe_out_axi_wr_master dut (
    .clk            (clk),
    .rst            (rst),
`ifdef RLWE_OUT_WR_PERF_EN
    .perf_busy_cycles   (perf_busy_cycles),
    .perf_wstall_cycles (perf_wstall_cycles),
`endif
    .start          (start),
    .base_addr      (base_addr),
    .num_lines      (num_lines),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .fifo_empty     (fifo_empty),
    .fifo_rd_addr   (fifo_rd_addr),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_rd_data   (fifo_rd_data),
    .fifo_rd_finish (fifo_rd_finish),
    .awid           (awid),
    .awaddr         (awaddr),
    .awlen          (awlen),
    .awsize         (awsize),
    .awburst        (awburst),
    .awvalid        (awvalid),
    .awready        (awready),
    .wdata          (wdata),
    .wstrb          (wstrb),
    .wlast          (wlast),
    .wvalid         (wvalid),
    .wready         (wready),
    .bid            (bid),
    .bresp          (bresp),
    .bvalid         (bvalid),
    .bready         (bready)
  );

  function automatic logic [511:0] line(input logic [15:0] t,
                                        input logic [15:0] i);
    return {16{t, i}};
  endfunction

  task automatic chk(input string nm, input logic [767:0] act,
                     input logic [767:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_burst(input logic [63:0] a, input int n,
                           input int first);
    aw_q.push_back({16'h0, a, 8'(n - 1), 3'd6, 2'b01});
    for (int k = 0; k < n; k++) begin
      w_q.push_back({{64{1'b1}}, line(tag, 16'(first + k)), k == n - 1});
    end
  endtask

  task automatic issue(input logic [63:0] a, input int n);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = a;
    num_lines = 10'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input logic exp_fin);
    int t;
    for (t = 0; t < 20000; t++) begin
      @(negedge clk);
      if (done) break;
    end
    if (t == 20000) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done");
    end else begin
      chk("rd_finish_with_done", fifo_rd_finish, exp_fin);
      chk("busy_at_done", busy, 1'b0);
    end
    chk("aw_q_drained", aw_q.size(), 0);
    chk("w_q_drained", w_q.size(), 0);
  endtask

  // FIFO read port: 1-cycle latency
  always @(posedge clk) begin
    if (fifo_rd_en) fifo_rd_data <= line(tag, {7'd0, fifo_rd_addr});
  end

  initial begin
    wready = 1'b1;
    forever begin
      @(posedge clk); #1;
      wready = wr_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // B responder: one response per completed burst
  initial begin
    bvalid = 1'b0;
    bresp = 2'b00;
    bid = '0;
    forever begin
      @(negedge clk);
      if (!rst && wvalid && wready && wlast) begin
        @(posedge clk); #1;
        bvalid = 1'b1;
        bresp = (bcount == slverr_at) ? 2'b10 : 2'b00;
        @(negedge clk);
        while (!bready) @(negedge clk);
        @(posedge clk); #1;
        bvalid = 1'b0;
        bresp = 2'b00;
        bcount++;
      end
    end
  end

  initial begin
    int endb;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (awvalid && awready) begin
          endb = int'(awaddr[11:0]) + (int'(awlen) + 1) * 64;
          chk("aw_4k_cross", endb > 4096, 1'b0);
          if (aw_q.size() == 0) begin
            chk("aw_unexpected", {awaddr, awlen}, '0);
          end else begin
            chk("aw_fields", {awid, awaddr, awlen, awsize, awburst},
                aw_q.pop_front());
          end
        end
        if (wvalid && wready) begin
          if (w_q.size() == 0) begin
            chk("w_unexpected", wdata, '0);
          end else begin
            chk("w_beat", {wstrb, wdata, wlast}, w_q.pop_front());
          end
        end
        if (fifo_rd_finish) fin_cnt++;
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    bit seen_aw;
    int t;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_lines = '0;
    fifo_empty = 1'b0;
    awready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {busy, done, err, fifo_rd_addr, fifo_rd_en,
        fifo_rd_finish, awvalid, wvalid, wlast, bready}, '0);
    chk("reset_axi", {awid, awaddr, awlen, awsize, awburst, wstrb}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 512 lines from 0x1000: 32 x 16-beat bursts
    tag = 16'h00A1;
    bcount = 0;
    for (int i = 0; i < 32; i++) begin
      exp_burst(64'h1000 + 64'(i) * 64'h400, 16, i * 16);
    end
    issue(64'h1000, 512);
    wait_done(1'b1);
    chk("t1_err", err, 1'b0);

    // page-crossing split at 0x2000
    tag = 16'h00B2;
    exp_burst(64'h1F80, 2, 0);
    exp_burst(64'h2000, 16, 2);
    exp_burst(64'h2400, 2, 18);
    issue(64'h1F80, 20);
    wait_done(1'b1);

    // wready backpressure at ~30%
    tag = 16'h00C3;
    wr_rand = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_burst(64'(i) * 64'h400, 16, i * 16);
    end
    issue(64'h0, 64);
    wait_done(1'b1);
    wr_rand = 1'b0;

    // FIFO empty for 100 cycles
    tag = 16'h00D4;
    fifo_empty = 1'b1;
    exp_burst(64'h8000, 16, 0);
    issue(64'h8000, 16);
    seen_aw = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (awvalid) seen_aw = 1'b1;
    end
    chk("no_aw_while_empty", seen_aw, 1'b0);
    chk("busy_while_empty", busy, 1'b1);
    @(posedge clk); #1;
    fifo_empty = 1'b0;
    wait_done(1'b1);

    // SLVERR on second burst
    tag = 16'h00E5;
    bcount = 0;
    slverr_at = 1;
    for (int i = 0; i < 3; i++) begin
      exp_burst(64'h3000 + 64'(i) * 64'h400, 16, i * 16);
    end
    issue(64'h3000, 48);
    wait_done(1'b1);
    chk("slverr_sticky", err, 1'b1);
    slverr_at = -1;
    tag = 16'h00F6;
    exp_burst(64'h5000, 16, 0);
    issue(64'h5000, 16);
    @(negedge clk);
    chk("err_cleared_by_start", err, 1'b0);
    wait_done(1'b1);
    chk("err_after_clean", err, 1'b0);

    // zero-length command
    issue(64'h9000, 0);
    @(negedge clk);
    chk("zero_done", {done, busy, fifo_rd_finish, awvalid}, 4'b1000);
    @(negedge clk);
    chk("zero_done_1cyc", done, 1'b0);

    // reset during W
    tag = 16'h0017;
    exp_burst(64'h0, 16, 0);
    issue(64'h0, 32);
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (wvalid) break;
    end
    chk("reached_w", t < 50, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ctrl", {busy, done, err, fifo_rd_addr, fifo_rd_en,
        fifo_rd_finish, awvalid, wvalid, wlast, bready}, '0);
    chk("rst_mid_axi", {awid, awaddr, awlen, awsize, awburst, wstrb}, '0);
    chk("rst_mid_wdata", wdata, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    aw_q.delete();
    w_q.delete();
    repeat (20) @(negedge clk);
    chk("rd_finish_count", fin_cnt, 6);
    chk("done_count", done_cnt, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rlwe_out_axi_wr_master.md
Name: rlwe_out_axi_wr_master

Overview:
- AXI4 write master that drains one completed RLWE line buffer from the RLWE output FIFO into CL DDR.
- It is the reader end of the acc-to-output-FIFO write path: it consumes the FIFO's read port and signals rd_finish when the whole buffer has been written out.
- It sits beside the key loader on the DDR-side AXI crossbar.
- Started by a top-control command carrying a DDR base address and a line count.

Parameters:
- AXI_DATA_WIDTH, 512: beat width; equals BIT_WIDTH*LINE_SIZE.
- AXI_ADDR_WIDTH, 64: DDR byte address width.
- AXI_ID_WIDTH, 16: AXI ID width; all transactions use ID 0.
- LINE_ADDR_WIDTH, 9: FIFO line address width.
- MAX_BURST, 16: maximum beats per burst, range 1..256.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command pulse; ignored while busy=1.
- base_addr  in  AXI_ADDR_WIDTH  DDR byte address; bits [5:0] must be 0.
- num_lines  in  LINE_ADDR_WIDTH+1  number of lines to transfer, 0..2^LINE_ADDR_WIDTH.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky: some BRESP was not OKAY; cleared by the next accepted start.
- fifo_empty  in  1  output FIFO has no completed buffer.
- fifo_rd_addr  out  LINE_ADDR_WIDTH  line read address.
- fifo_rd_en  out  1  read strobe.
- fifo_rd_data  in  AXI_DATA_WIDTH  read data, valid exactly 1 cycle after fifo_rd_en.
- fifo_rd_finish  out  1  one-cycle pulse that pops the buffer.
- Write address channel: awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awvalid (out); awready (in).
- Write data channel: wdata, wstrb[AXI_DATA_WIDTH/8], wlast, wvalid (out); wready (in).
- Write response channel: bid, bresp[1:0], bvalid (in); bready (out).

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE and the skid buffer is empty.
- An rst assertion in mid-operation aborts immediately. No rd_finish is issued and the FIFO buffer stays unpopped. rst is global, so the DDR side resets together with this block.
- Constant AXI fields: awsize=6, awburst=INCR, awid=0, wstrb all ones.
- start in IDLE latches base_addr and num_lines, clears err, and sets busy.
- num_lines=0: done is asserted in the next cycle and busy drops with it. There is no AXI traffic and no rd_finish.
- FSM states and transitions:
  - IDLE: start → WAIT_FIFO.
  - WAIT_FIFO: hold while fifo_empty=1; otherwise → AW.
  - AW: awvalid=1 with awaddr=cur_addr and awlen=len-1, where len = min(MAX_BURST, remaining, 64-cur_addr[11:6]). The burst never crosses a 4 KB boundary. On awvalid&&awready → W.
  - W: stream len beats, with wlast on the final beat. After the last handshake → B.
  - B: bready=1. On bvalid, an OKAY-free response sets err. Then cur_addr += len*64 and remaining -= len. If remaining=0 → FINISH; otherwise → AW.
  - FINISH: fifo_rd_finish=1 and done=1 for one cycle, busy=0 → IDLE.
- Only one burst is outstanding; AW for the next burst waits for B.
- A non-OKAY response does not stop the command; the remaining bursts are still issued.
- Data path:
  - rd_addr starts at 0 and increments on each fifo_rd_en.
  - Reads are issued from AW onward, as long as the 2-entry skid buffer has space for the in-flight read and the burst still has lines to fetch.
  - wvalid = skid buffer non-empty while in W.
  - Data is accepted with no bubbles when wready stays high: 1 beat/cycle sustained after the 1-cycle read latency.
  - fifo_rd_data is never dropped under backpressure, because the occupancy plus in-flight reads stays ≤ 2.
- AW and the start of prefetch are independent; awready stalls must not lose prefetched data.
- done and fifo_rd_finish are asserted in the same cycle.

Optional Feature:
- Macro: RLWE_OUT_WR_PERF_EN.
- When defined, two 32-bit saturating output ports are added, both cleared on an accepted start:
  - perf_busy_cycles counts cycles with busy=1.
  - perf_wstall_cycles counts cycles with wvalid&&!wready.
- When undefined, these ports and their counters do not exist and behaviour is otherwise identical.

Decomposition:
- The shared package holds:
  - AXI constants AXI_BURST_INCR, AXI_RESP_OKAY and AXI_SIZE_64B.
  - The 4 KB page-beat constant (64).
  - typedef enum rlwe_wr_state_e {IDLE, WAIT_FIFO, AW, W, B, FINISH}.
- One sub-module: rlwe_wr_skid_buf, a 2-entry valid/ready buffer with a credit output used to gate fifo_rd_en.

Test Plan:
- start, base 0x1000, num_lines 512, wready and awready held at 1 → 32 bursts of awlen=15 at 0x1000, 0x1400, … Data matches FIFO lines 0..511 in order. There is one rd_finish and done in the same cycle, and err=0.
- base 0x1F80, num_lines 20 → bursts have awlen 1 @0x1F80, then 15 @0x2000, then 1 @0x2400. No burst crosses a 4 KB boundary.
- wready toggling pseudo-randomly at 30% duty, num_lines 64 → wdata equals lines 0..63 with no drop or duplicate, and wlast falls on every 16th beat.
- fifo_empty=1 for 100 cycles after start → no awvalid appears until empty falls. Then the transfer completes normally.
- Second burst gets bresp=SLVERR → err=1 and all remaining bursts complete with done. A following start clears err.
- num_lines=0 → done pulses 1 cycle after start with no AXI activity. Separately, rst asserted during W → all outputs 0 in the next cycle and no rd_finish.
